// File: rtl/arm_idex_operand_stage_pkg.sv
// Shared types for the ID/EX operand stage: forward-select codes, stall FSM states, word types.
// Operand slot count is fixed at three (Rn, Rm, Rs) for the whole slice.
package arm_idex_operand_stage_pkg;

  localparam int NUM_SLOTS = 3;
  localparam int CNT_W     = 16;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_EX   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_RSVD = 2'b11;

  localparam logic [CNT_W-1:0] STALL_CNT_MAX = {CNT_W{1'b1}};

  typedef logic [31:0] word_t;
  typedef logic [3:0]  reg_num_t;
  typedef logic [1:0]  fwd_sel_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MACWAIT = 2'd2
  } stage_state_t;

  // A slot conflicts with the EX destination only if it is really read.
  function automatic logic slot_hazard(input logic     slot_read,
                                       input reg_num_t src_num,
                                       input reg_num_t dst_num);
    return slot_read && (src_num == dst_num);
  endfunction

endpackage

// File: rtl/arm_idex_operand_stage_if.sv
// ID-side inputs, EX/MEM bypass sources and registered ID/EX outputs of the operand stage.
// slave = the operand stage itself, master = the surrounding pipeline.
interface arm_idex_operand_stage_if;
  import arm_idex_operand_stage_pkg::*;

  logic                 id_valid;
  word_t                id_inst;
  word_t                id_pc;
  word_t                rf_data [0:NUM_SLOTS-1];
  fwd_sel_t             forward [0:NUM_SLOTS-1];
  word_t                ex_result;
  word_t                mem_result;
  logic                 ex_is_load;
  logic                 ex_rd_we;
  reg_num_t             ex_rd_num;
  reg_num_t             data_reg_num [0:NUM_SLOTS-1];
  logic [NUM_SLOTS-1:0] mask_of_real_read_reg;
  logic                 ex_busy;
  logic                 flush;

  logic                 idex_valid;
  word_t                idex_inst;
  word_t                idex_pc;
  word_t                idex_op [0:NUM_SLOTS-1];
  logic                 id_stall;
  logic [CNT_W-1:0]     stall_count;

  modport master (
    output id_valid, id_inst, id_pc, rf_data, forward, ex_result, mem_result,
           ex_is_load, ex_rd_we, ex_rd_num, data_reg_num, mask_of_real_read_reg,
           ex_busy, flush,
    input  idex_valid, idex_inst, idex_pc, idex_op, id_stall, stall_count
  );

  modport slave (
    input  id_valid, id_inst, id_pc, rf_data, forward, ex_result, mem_result,
           ex_is_load, ex_rd_we, ex_rd_num, data_reg_num, mask_of_real_read_reg,
           ex_busy, flush,
    output idex_valid, idex_inst, idex_pc, idex_op, id_stall, stall_count
  );

endinterface

// File: rtl/arm_operand_mux.sv
// Per-slot operand source select: register file, EX result or MEM write-back data.
// Purely combinational; the reserved code falls back to the register file.
module arm_operand_mux
  import arm_idex_operand_stage_pkg::*;
(
  input  fwd_sel_t sel,
  input  word_t    rf_data,
  input  word_t    ex_result,
  input  word_t    mem_result,
  output word_t    op
);

  always_comb begin
    op = rf_data;
    case (sel)
      FWD_EX:  op = ex_result;
      FWD_MEM: op = mem_result;
      default: op = rf_data;
    endcase
  end

endmodule

// File: rtl/arm_idex_operand_stage.sv
// ID/EX operand register with bypass muxing, load-use bubble insertion and MAC-busy hold.
// 1-cycle ID->EX latency; id_stall holds IF/ID on ex_busy or load-use unless a flush wins.
module arm_idex_operand_stage
  import arm_idex_operand_stage_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  arm_idex_operand_stage_if.slave  bus
);

  stage_state_t     state;
  logic             idex_valid_q;
  word_t            idex_inst_q;
  word_t            idex_pc_q;
  word_t            idex_op_q [0:NUM_SLOTS-1];
  logic [CNT_W-1:0] stall_cnt_q;

  word_t            op_sel [0:NUM_SLOTS-1];
  logic             src_match;
  logic             load_use;
  logic             stall;

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    arm_operand_mux u_operand_mux (
      .sel        (bus.forward[s]),
      .rf_data    (bus.rf_data[s]),
      .ex_result  (bus.ex_result),
      .mem_result (bus.mem_result),
      .op         (op_sel[s])
    );
  end

  // The EX-side load is only real while the ID/EX register holds a valid instruction.
  always_comb begin
    src_match = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      src_match = src_match |
                  slot_hazard(bus.mask_of_real_read_reg[s], bus.data_reg_num[s], bus.ex_rd_num);
    end
    load_use = src_match && bus.ex_is_load && bus.ex_rd_we && bus.id_valid && idex_valid_q;
  end

  assign stall = !rst && !bus.flush && (bus.ex_busy || load_use);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      idex_valid_q <= 1'b0;
      idex_inst_q  <= '0;
      idex_pc_q    <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        idex_op_q[s] <= '0;
      end
      stall_cnt_q  <= '0;
    end else begin
      if (stall && (stall_cnt_q != STALL_CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end

      case (state)
        RUN: begin
          if (bus.flush)        state <= RUN;
          else if (bus.ex_busy) state <= MACWAIT;
          else if (load_use)    state <= LDSTALL;
          else                  state <= RUN;
        end
        LDSTALL: state <= RUN;
        MACWAIT: begin
          if (bus.flush)        state <= RUN;
          else if (bus.ex_busy) state <= MACWAIT;
          else                  state <= RUN;
        end
        default: state <= RUN;
      endcase

      // Flush beats a MAC hold, which beats a load-use bubble.
      if (bus.flush) begin
        idex_valid_q <= 1'b0;
      end else if (bus.ex_busy) begin
        idex_valid_q <= idex_valid_q;
      end else if (load_use) begin
        idex_valid_q <= 1'b0;
      end else begin
        idex_valid_q <= bus.id_valid;
        idex_inst_q  <= bus.id_inst;
        idex_pc_q    <= bus.id_pc;
        for (int s = 0; s < NUM_SLOTS; s++) begin
          idex_op_q[s] <= op_sel[s];
        end
      end
    end
  end

  assign bus.idex_valid  = idex_valid_q;
  assign bus.idex_inst   = idex_inst_q;
  assign bus.idex_pc     = idex_pc_q;
  assign bus.idex_op     = idex_op_q;
  assign bus.id_stall    = stall;
  assign bus.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_arm_idex_operand_stage.sv
// Randomized + directed bench for arm_idex_operand_stage with a queue-based scoreboard.
module tb_arm_idex_operand_stage;
  import arm_idex_operand_stage_pkg::*;

  typedef struct {
    logic              valid;
    word_t             inst;
    word_t             pc;
    logic [2:0][31:0]  op;
    logic [15:0]       cnt;
  } exp_t;

  logic clk;
  logic rst;
  arm_idex_operand_stage_if bus ();

  arm_idex_operand_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  exp_t exp_q[$];

  logic             m_valid;
  word_t            m_inst;
  word_t            m_pc;
  logic [2:0][31:0] m_op;
  logic [15:0]      m_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic word_t pick(input logic [1:0] f, input word_t rf, input word_t ex, input word_t mem);
    word_t src [4];
    src = '{rf, ex, mem, rf};
    return src[f];
  endfunction

  function automatic bit model_hazard();
    bit hit = 0;
    for (int s = 0; s < 3; s++)
      if (bus.mask_of_real_read_reg[s] && bus.data_reg_num[s] == bus.ex_rd_num) hit = 1;
    return hit && m_valid && bus.id_valid && bus.ex_is_load && bus.ex_rd_we;
  endfunction

  // Monitor: one expected record per clock edge, compared after the edge settles.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("idex_valid", 32'(bus.idex_valid), 32'(e.valid));
        check("stall_count", 32'(bus.stall_count), 32'(e.cnt));
        if (e.valid) begin
          check("idex_inst", bus.idex_inst, e.inst);
          check("idex_pc", bus.idex_pc, e.pc);
          for (int s = 0; s < 3; s++)
            check($sformatf("idex_op%0d", s), bus.idex_op[s], e.op[s]);
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.id_valid = 0; bus.id_inst = '0; bus.id_pc = '0;
    bus.ex_result = '0; bus.mem_result = '0;
    bus.ex_is_load = 0; bus.ex_rd_we = 0; bus.ex_rd_num = '0;
    bus.mask_of_real_read_reg = '0; bus.ex_busy = 0; bus.flush = 0;
    for (int s = 0; s < 3; s++) begin
      bus.rf_data[s] = '0; bus.forward[s] = FWD_RF; bus.data_reg_num[s] = '0;
    end
  endtask

  task automatic rand_inputs();
    bus.id_valid = 1'($urandom_range(0, 3) != 0);
    bus.id_inst = $urandom(); bus.id_pc = $urandom();
    bus.ex_result = $urandom(); bus.mem_result = $urandom();
    bus.ex_is_load = 1'($urandom_range(0, 2) == 0);
    bus.ex_rd_we = 1'($urandom_range(0, 3) != 0);
    bus.ex_rd_num = 4'($urandom_range(0, 3));
    bus.mask_of_real_read_reg = 3'($urandom_range(0, 7));
    bus.ex_busy = 1'($urandom_range(0, 5) == 0);
    bus.flush = 1'($urandom_range(0, 7) == 0);
    for (int s = 0; s < 3; s++) begin
      bus.rf_data[s] = $urandom();
      bus.forward[s] = 2'($urandom_range(0, 3));
      bus.data_reg_num[s] = 4'($urandom_range(0, 3));
    end
  endtask

  // Called just after a falling edge with inputs driven; returns after the next falling edge.
  task automatic step();
    bit haz, stall;
    #1;
    haz = model_hazard();
    stall = !bus.flush && (bus.ex_busy || haz);
    check("id_stall", 32'(bus.id_stall), 32'(stall));
    if (stall && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (bus.flush) m_valid = 0;
    else if (bus.ex_busy) ;
    else if (haz) m_valid = 0;
    else begin
      m_valid = bus.id_valid; m_inst = bus.id_inst; m_pc = bus.id_pc;
      for (int s = 0; s < 3; s++)
        m_op[s] = pick(bus.forward[s], bus.rf_data[s], bus.ex_result, bus.mem_result);
    end
    exp_q.push_back('{m_valid, m_inst, m_pc, m_op, m_cnt});
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.idex_valid), 32'd0);
    check({tag, "_inst"}, bus.idex_inst, 32'd0);
    check({tag, "_pc"}, bus.idex_pc, 32'd0);
    for (int s = 0; s < 3; s++) check($sformatf("%s_op%0d", tag, s), bus.idex_op[s], 32'd0);
    check({tag, "_cnt"}, 32'(bus.stall_count), 32'd0);
    check({tag, "_stall"}, 32'(bus.id_stall), 32'd0);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    #1 rst = 1;
    #1 check_zero_outputs(tag);
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    m_valid = 0; m_inst = '0; m_pc = '0; m_op = '0; m_cnt = '0;
    #1;
  endtask

  initial begin
    logic [15:0] cnt0;
    word_t held_inst;
    rst = 1;
    idle_inputs();
    m_valid = 0; m_inst = '0; m_pc = '0; m_op = '0; m_cnt = '0;
    apply_reset("rst_init");

    // Forward mux on slot 0
    bus.id_valid = 1; bus.rf_data[0] = 32'h11; bus.ex_result = 32'h22; bus.mem_result = 32'h33;
    bus.forward[0] = FWD_EX;   step(); check("fwd_ex",   bus.idex_op[0], 32'h22);
    bus.forward[0] = FWD_MEM;  step(); check("fwd_mem",  bus.idex_op[0], 32'h33);
    bus.forward[0] = FWD_RSVD; step(); check("fwd_rsvd", bus.idex_op[0], 32'h11);

    // Load-use on r3 in slot 1
    apply_reset("rst_lu");
    bus.id_valid = 1; bus.id_inst = 32'hE593_3000; step();
    bus.id_inst = 32'hE083_1003; bus.id_pc = 32'h104;
    bus.ex_is_load = 1; bus.ex_rd_we = 1; bus.ex_rd_num = 4'd3;
    bus.data_reg_num[1] = 4'd3; bus.mask_of_real_read_reg = 3'b010; bus.forward[1] = FWD_RF;
    #1 check("lu_stall", 32'(bus.id_stall), 32'd1);
    step(); check("lu_bubble", 32'(bus.idex_valid), 32'd0);
    bus.ex_is_load = 0; bus.forward[1] = FWD_MEM; bus.mem_result = 32'hCAFE_0003;
    #1 check("lu_release", 32'(bus.id_stall), 32'd0);
    step();
    check("lu_issue_op1", bus.idex_op[1], 32'hCAFE_0003);
    check("lu_count", 32'(bus.stall_count), 32'd1);

    // MAC wait for three cycles
    idle_inputs(); bus.id_valid = 1; bus.id_inst = 32'hAAAA_0001; step();
    held_inst = bus.idex_inst; cnt0 = bus.stall_count;
    bus.id_inst = 32'hBBBB_0002; bus.ex_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1 check("mac_stall", 32'(bus.id_stall), 32'd1);
      step(); check("mac_hold", bus.idex_inst, held_inst);
    end
    bus.ex_busy = 0;
    #1 check("mac_done_stall", 32'(bus.id_stall), 32'd0);
    step();
    check("mac_issue", bus.idex_inst, 32'hBBBB_0002);
    check("mac_count", 32'(bus.stall_count - cnt0), 32'd3);

    // Hazard and flush together
    idle_inputs(); bus.id_valid = 1; step();
    bus.ex_is_load = 1; bus.ex_rd_we = 1; bus.ex_rd_num = 4'd5;
    bus.data_reg_num[0] = 4'd5; bus.mask_of_real_read_reg = 3'b001; bus.flush = 1;
    #1 check("flush_stall", 32'(bus.id_stall), 32'd0);
    step(); check("flush_valid", 32'(bus.idex_valid), 32'd0);
    idle_inputs(); bus.id_valid = 1; bus.id_inst = 32'h1234_5678; step();
    check("flush_run", 32'(bus.idex_valid), 32'd1);

    // Reset in the middle of a MAC wait
    bus.ex_busy = 1; step(); step();
    apply_reset("rst_mac");
    bus.id_valid = 1; bus.id_inst = 32'h0BAD_F00D;
    #1 check("post_rst_stall", 32'(bus.id_stall), 32'd0);
    step(); check("post_rst_issue", 32'(bus.idex_valid), 32'd1);

    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      step();
    end

    // Saturation of the stall counter
    apply_reset("rst_sat");
    bus.ex_busy = 1;
    for (int i = 0; i < 70000; i++) step();
    check("sat_count", 32'(bus.stall_count), 32'h0000_FFFF);
    step();
    check("sat_nowrap", 32'(bus.stall_count), 32'h0000_FFFF);
    bus.ex_busy = 0; step();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arm_idex_operand_stage.md
ARM_IDEX_OPERAND_STAGE -- requirements
Module: arm_idex_operand_stage

Interface
REQ-001 The block SHALL have these ports: clk, input, 1, sole clock, all state updates on its rising edge.
REQ-002 The block SHALL have these ports: rst, input, 1, asynchronous, active-high reset.
REQ-003 The block SHALL have these ports: id_valid, input, 1, the ID stage holds a real instruction.
REQ-004 The block SHALL have these ports: id_inst and id_pc, input, 32 each, the instruction word and PC of the ID instruction.
REQ-005 The block SHALL have these ports: rf_data[0:2], input, 32 each, register-file read data for operand slots 0..2.
REQ-006 The block SHALL have these ports: forward[0:2], input, 2 each, per-slot operand source select from the forwarding unit.
REQ-007 The block SHALL have these ports: ex_result, input, 32, the current EX-stage result.
REQ-008 The block SHALL have these ports: mem_result, input, 32, the current MEM-stage write-back data.
REQ-009 The block SHALL have these ports: ex_is_load, ex_rd_we and ex_rd_num, input, 1/1/4, describing the instruction currently in EX.
REQ-010 The block SHALL have these ports: data_reg_num[0:2] and mask_of_real_read_reg, input, 4 each and 3, giving ID source register numbers and the slots actually read.
REQ-011 The block SHALL have these ports: ex_busy, input, 1, EX is in a multi-cycle MAC and cannot accept a new instruction.
REQ-012 The block SHALL have these ports: flush, input, 1, a taken branch kills the younger instructions.
REQ-013 The block SHALL have these ports: idex_valid, idex_inst, idex_pc and idex_op[0:2], output, 1/32/32/32 each, registered EX-stage inputs.
REQ-014 The block SHALL have these ports: id_stall, output, 1, combinational, holding the IF and ID stages.
REQ-015 The block SHALL have these ports: stall_count, output, 16, saturating count of stall cycles.

Function
REQ-016 The operand mux SHALL select, per slot, according to forward: 00 selects rf_data, 01 selects ex_result, 10 selects mem_result, and 11 (reserved) selects rf_data.
REQ-017 A load-use hazard SHALL be signalled when ex_is_load=1, ex_rd_we=1, and some slot i has mask bit i=1 with data_reg_num[i]==ex_rd_num, while id_valid=1 and idex_valid=1.
REQ-018 The state machine SHALL have the states RUN, LDSTALL and MACWAIT, and SHALL enter RUN from reset.
REQ-019 RUN transitions: when flush=1, remain in RUN; otherwise, when ex_busy=1, go to MACWAIT; otherwise, on a load-use hazard, go to LDSTALL; otherwise remain in RUN.
REQ-020 LDSTALL SHALL last exactly 1 cycle and then return to RUN; the re-presented ID instruction then forwards with select 10.
REQ-021 MACWAIT SHALL remain while ex_busy=1 and SHALL return to RUN on the first cycle with ex_busy=0.
REQ-022 A flush in MACWAIT or LDSTALL SHALL go to RUN.
REQ-023 Register-update priority SHALL be, per edge: flush, then ex_busy, then hazard, then normal.
REQ-024 On flush: idex_valid SHALL become 0; the other idex_* registers are don't-care.
REQ-025 On ex_busy=1: all idex_* registers SHALL hold their values.
REQ-026 On a load-use hazard: idex_valid SHALL become 0 (bubble); the other idex_* registers are don't-care.
REQ-027 On a normal edge: idex_valid SHALL take id_valid, idex_inst/pc SHALL take id_inst/pc, and idex_op[i] SHALL take the mux output.
REQ-028 id_stall SHALL equal !flush && (ex_busy || load-use hazard).
REQ-029 stall_count SHALL increment by 1 on every edge with id_stall=1 and SHALL saturate at 16'hFFFF.
REQ-030 Latency SHALL be 1 cycle from ID to the idex outputs.

Reset
REQ-031 On rst=1, asynchronously: state SHALL be RUN, idex_valid SHALL be 0, and idex_inst, idex_pc, idex_op[0:2] and stall_count SHALL be 0.
REQ-032 id_stall SHALL be 0 while reset is asserted, overriding REQ-028.
REQ-033 Reset SHALL abort any LDSTALL or MACWAIT with no residual stall after release.

Structure
REQ-034 The shared package SHALL hold the forward-select encodings (FWD_RF=2'b00, FWD_EX=2'b01, FWD_MEM=2'b10) and the state enum {RUN, LDSTALL, MACWAIT}.
REQ-035 One sub-module, arm_operand_mux, SHALL implement the per-slot 3:1 select and SHALL be instantiated three times.

Verification
REQ-036 Forward mux: rf_data[0]=0x11, ex_result=0x22, mem_result=0x33, forward[0]=01/10/11 -> idex_op[0]=0x22/0x33/0x11 after 1 edge.
REQ-037 Load-use: EX holds load r3, ID reads r3 in slot 1 -> id_stall=1 for 1 cycle, then a bubble with idex_valid=0, then the instruction issues with forward[1]=10 and stall_count=1.
REQ-038 MAC wait: ex_busy=1 for 3 cycles -> idex_* held and id_stall=1 for 3 cycles, back in RUN on cycle 4, stall_count=3.
REQ-039 Flush during stall: hazard and flush=1 in the same cycle -> id_stall=0, idex_valid=0 next edge, state RUN.
REQ-040 Reset mid-MACWAIT: rst pulsed while ex_busy=1 -> all outputs 0 immediately, state RUN after release.
REQ-041 Saturation: force 70000 stall cycles -> stall_count=16'hFFFF and no wrap.
